// File: rtl/mont_pkg.sv
// ---------------------------------------------------------------------------
// mont_pkg
//   Shared definitions for Montgomery-domain blocks.
//
//   mont_state_t : controller state for the iterative converters
//                  (IDLE -> STEP -> DONE -> IDLE).
// ---------------------------------------------------------------------------
package mont_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    DONE = 2'd2
  } mont_state_t;

endpackage : mont_pkg

// File: rtl/mod_double_step.sv
// ---------------------------------------------------------------------------
// mod_double_step
//   Combinational modular doubling: dbl = (2*acc) mod n.
//   Requires acc < n. Under that precondition 2*acc < 2n, so one
//   conditional subtraction is enough to bring the result below n.
//
//   Ports
//     acc  in   WIDTH  operand, must be < n
//     n    in   WIDTH  modulus
//     dbl  out  WIDTH  (2*acc) mod n
// ---------------------------------------------------------------------------
module mod_double_step #(
  parameter int WIDTH = 512
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] dbl
);

  // 2*acc needs one extra bit; the compare must use that bit or large
  // operands would wrap and skip the subtraction.
  logic [WIDTH:0] twice;
  logic [WIDTH:0] n_ext;
  logic [WIDTH:0] diff;

  always_comb begin
    twice = {acc, 1'b0};
    n_ext = {1'b0, n};
    diff  = twice - n_ext;
    if (twice >= n_ext) begin
      dbl = diff[WIDTH-1:0];
    end else begin
      dbl = twice[WIDTH-1:0];
    end
  end

endmodule : mod_double_step

// File: rtl/mont_encoder.sv
// ---------------------------------------------------------------------------
// mont_encoder
//   Converts a normal-form operand into Montgomery form:
//     x_mont   = x * 2^WIDTH mod N
//     one_mont =     2^WIDTH mod N
//   by WIDTH rounds of bit-serial modular doubling (no multiplier).
//
//   Ports
//     clk_in     in   1      clock, rising edge
//     rst_n_in   in   1      asynchronous active-low reset
//     x          in   WIDTH  operand, sampled on accept
//     modulo     in   WIDTH  N (odd, nonzero), sampled on accept
//     valid_in   in   1      request; accepted when busy_out = 0
//     ready_in   in   1      downstream takes the result
//     x_mont     out  WIDTH  x*R mod N
//     one_mont   out  WIDTH  R mod N
//     err_out    out  1      illegal request (qualified by valid_out)
//     valid_out  out  1      result valid, held until ready_in
//     busy_out   out  1      accept .. result handshake
// ---------------------------------------------------------------------------
module mont_encoder
  import mont_pkg::*;
#(
  parameter int WIDTH = 512
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] modulo,
  input  logic             valid_in,
  input  logic             ready_in,
  output logic [WIDTH-1:0] x_mont,
  output logic [WIDTH-1:0] one_mont,
  output logic             err_out,
  output logic             valid_out,
  output logic             busy_out
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  mont_state_t state, state_nxt;

  logic [WIDTH-1:0] n_reg;
  logic [WIDTH-1:0] acc_x;
  logic [WIDTH-1:0] acc_1;
  logic [WIDTH-1:0] dbl_x;
  logic [WIDTH-1:0] dbl_1;
  logic [CNT_W-1:0] step_cnt;

  // Control strobes decoded from state and inputs.
  logic illegal;
  logic load_start;
  logic load_err;
  logic do_step;
  logic last_step;
  logic raise_valid;
  logic handshake;

  // -------------------------------------------------------------------------
  // Datapath: two parallel modular doublers.
  // -------------------------------------------------------------------------
  mod_double_step #(.WIDTH(WIDTH)) u_dbl_x (
    .acc (acc_x),
    .n   (n_reg),
    .dbl (dbl_x)
  );

  mod_double_step #(.WIDTH(WIDTH)) u_dbl_1 (
    .acc (acc_1),
    .n   (n_reg),
    .dbl (dbl_1)
  );

  // -------------------------------------------------------------------------
  // FSM: state register.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic.
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (valid_in) begin
          state_nxt = illegal ? DONE : STEP;
        end
      end
      STEP: begin
        if (step_cnt == LAST_STEP) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (valid_out && ready_in) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: output / control decode.
  // -------------------------------------------------------------------------
  always_comb begin
    illegal     = (modulo[0] == 1'b0) || (x >= modulo);
    load_start  = 1'b0;
    load_err    = 1'b0;
    do_step     = 1'b0;
    last_step   = 1'b0;
    raise_valid = 1'b0;
    handshake   = 1'b0;
    unique case (state)
      IDLE: begin
        load_start = valid_in && !illegal;
        load_err   = valid_in && illegal;
      end
      STEP: begin
        do_step   = 1'b1;
        last_step = (step_cnt == LAST_STEP);
      end
      DONE: begin
        // An error request enters DONE with valid_out still low, so the
        // result shows up one edge after the accept.
        raise_valid = !valid_out;
        handshake   = valid_out && ready_in;
      end
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Registers and output handshake.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      n_reg     <= '0;
      acc_x     <= '0;
      acc_1     <= '0;
      step_cnt  <= '0;
      x_mont    <= '0;
      one_mont  <= '0;
      err_out   <= 1'b0;
      valid_out <= 1'b0;
      busy_out  <= 1'b0;
    end else begin
      if (load_start) begin
        n_reg    <= modulo;
        acc_x    <= x;
        // 1 mod N is 0 when N = 1; keeps the doubler precondition acc < N.
        acc_1    <= (modulo == WIDTH'(1)) ? '0 : WIDTH'(1);
        step_cnt <= '0;
        busy_out <= 1'b1;
      end

      if (load_err) begin
        x_mont   <= '0;
        one_mont <= '0;
        err_out  <= 1'b1;
        busy_out <= 1'b1;
      end

      if (do_step) begin
        acc_x    <= dbl_x;
        acc_1    <= dbl_1;
        step_cnt <= step_cnt + 1'b1;
      end

      // The final doubling is written straight into the outputs so that
      // valid_out rises on the WIDTH-th step edge.
      if (last_step) begin
        x_mont    <= dbl_x;
        one_mont  <= dbl_1;
        err_out   <= 1'b0;
        valid_out <= 1'b1;
      end

      if (raise_valid) begin
        valid_out <= 1'b1;
      end

      if (handshake) begin
        valid_out <= 1'b0;
        busy_out  <= 1'b0;
      end
    end
  end

endmodule : mont_encoder

// File: tb/tb_mont_encoder.sv
module tb_mont_encoder;

  localparam int W = 8;

  logic         clk_in = 1'b0;
  logic         rst_n_in;
  logic [W-1:0] x;
  logic [W-1:0] modulo;
  logic         valid_in;
  logic         ready_in;
  logic [W-1:0] x_mont;
  logic [W-1:0] one_mont;
  logic         err_out;
  logic         valid_out;
  logic         busy_out;

  int checks = 0;
  int errors = 0;

  mont_encoder #(.WIDTH(W)) dut (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .x         (x),
    .modulo    (modulo),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .x_mont    (x_mont),
    .one_mont  (one_mont),
    .err_out   (err_out),
    .valid_out (valid_out),
    .busy_out  (busy_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Reference: plain modular arithmetic with R = 2^W.
  task automatic convert(input logic [W-1:0] xi, input logic [W-1:0] ni,
                         input int hold, input bit zero_wait);
    bit     bad;
    longint ex_x;
    longint ex_1;
    int     lat;
    bad  = (ni % 2 == 0) || (xi >= ni);
    ex_x = bad ? 0 : ((longint'(xi) << W) % longint'(ni));
    ex_1 = bad ? 0 : ((longint'(1) << W) % longint'(ni));

    x        = xi;
    modulo   = ni;
    valid_in = 1'b1;
    ready_in = zero_wait;
    tick();
    valid_in = 1'b0;
    check("busy_after_accept", busy_out, 1);

    // Inputs wander freely while busy; extra valid_in pulses must be ignored.
    lat = 0;
    while (valid_out !== 1'b1 && lat < 4 * W) begin
      x        = W'($urandom);
      modulo   = W'($urandom);
      valid_in = 1'($urandom);
      tick();
      lat++;
    end
    valid_in = 1'b0;
    check("latency", lat, bad ? 1 : W);
    check("x_mont", x_mont, ex_x);
    check("one_mont", one_mont, ex_1);
    check("err_out", err_out, bad);
    check("busy_while_valid", busy_out, 1);

    if (zero_wait) begin
      tick();
      check("zw_valid_one_cycle", valid_out, 0);
      check("zw_busy_clear", busy_out, 0);
      ready_in = 1'b0;
    end else begin
      for (int i = 0; i < hold; i++) begin
        valid_in = 1'b1;
        x        = W'($urandom);
        tick();
        check("bp_valid_held", valid_out, 1);
        check("bp_x_mont_stable", x_mont, ex_x);
        check("bp_one_mont_stable", one_mont, ex_1);
        check("bp_err_stable", err_out, bad);
        check("bp_busy_held", busy_out, 1);
      end
      valid_in = 1'b0;
      ready_in = 1'b1;
      tick();
      check("hs_valid_clear", valid_out, 0);
      check("hs_busy_clear", busy_out, 0);
      ready_in = 1'b0;
    end
  endtask

  initial begin
    logic [W-1:0] rn;
    logic [W-1:0] rx;

    rst_n_in = 1'b0;
    x        = '0;
    modulo   = '0;
    valid_in = 1'b0;
    ready_in = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    check("rst_valid", valid_out, 0);
    check("rst_busy", busy_out, 0);
    check("rst_err", err_out, 0);
    check("rst_x_mont", x_mont, 0);
    check("rst_one_mont", one_mont, 0);
    rst_n_in = 1'b1;
    tick();

    // Directed cases.
    convert(8'd5, 8'd13, 0, 1'b0);
    check("basic_x_mont_const", x_mont, 6);
    convert(8'd0, 8'd13, 1, 1'b0);
    convert(8'd12, 8'd13, 0, 1'b1);
    convert(8'd254, 8'd255, 2, 1'b0);
    convert(8'd3, 8'd12, 1, 1'b0);
    convert(8'd13, 8'd13, 0, 1'b1);
    convert(8'd5, 8'd13, 5, 1'b0);
    convert(8'd0, 8'd1, 0, 1'b0);

    // Reset in the middle of a conversion (after the 4th step edge).
    x        = 8'd7;
    modulo   = 8'd13;
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    repeat (4) tick();
    rst_n_in = 1'b0;
    #1;
    check("mid_rst_valid", valid_out, 0);
    check("mid_rst_busy", busy_out, 0);
    check("mid_rst_err", err_out, 0);
    check("mid_rst_x_mont", x_mont, 0);
    check("mid_rst_one_mont", one_mont, 0);
    #10;
    rst_n_in = 1'b1;
    repeat (W + 2) tick();
    check("post_rst_no_result", valid_out, 0);
    convert(8'd5, 8'd13, 0, 1'b0);

    // Randomized requests, mostly legal.
    for (int t = 0; t < 40; t++) begin
      rn = W'($urandom_range(1, 255));
      if ($urandom_range(0, 5) != 0) rn[0] = 1'b1;
      if ($urandom_range(0, 5) == 0) rx = W'($urandom);
      else                           rx = W'($urandom_range(0, int'(rn) - 1));
      convert(rx, rn, $urandom_range(0, 3), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mont_encoder
